// File: rtl/br_demux_bin_pkg.sv
// Package for the binary-select flow-controlled demux.
//   br_demux_bin_state_e : buffer occupancy (EMPTY, ONE, TWO)
//   sel_in_range()       : true when a select value addresses an existing pop port
package br_demux_bin_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } br_demux_bin_state_e;

    function automatic logic sel_in_range(input int unsigned sel,
                                          input int unsigned num_symbols);
        return sel < num_symbols;
    endfunction

endpackage

// File: rtl/br_demux_bin_flow_reg_stage.sv
// One buffer slot holding {data, select, valid}.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture in_data/in_select and set valid (wins over clear)
//   clear      : drop valid; data/select keep their last value
//   in_data    : payload to capture
//   in_select  : destination index to capture
//   valid      : slot occupied
//   data       : stored payload
//   select     : stored destination index
module br_demux_bin_flow_reg_stage
    import br_demux_bin_pkg::*;
#(
    parameter int SymbolWidth = 1,
    parameter int SelectWidth = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [SymbolWidth-1:0] in_data,
    input  logic [SelectWidth-1:0] in_select,
    output logic                   valid,
    output logic [SymbolWidth-1:0] data,
    output logic [SelectWidth-1:0] select
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            data   <= '0;
            select <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            data   <= in_data;
            select <= in_select;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/br_demux_bin_flow_reg.sv
// 1-to-N demultiplexer with binary select and ready/valid flow control.
// Each accepted {data, select} beat is presented on pop port [select] only,
// from a registered head slot; delivery is strictly in order across ports.
//
// Configuration macro BR_DEMUX_BIN_FLOW_REG_SKID_EN:
//   defined   : 2-entry buffer (head + skid), push_ready is a register
//   undefined : 1-entry buffer, push_ready depends combinationally on pop_ready
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_valid   : push beat valid
//   push_ready   : push beat accepted when push_valid & push_ready
//   push_select  : destination pop port index
//   push_data    : payload
//   pop_valid    : per-port valid, at most one bit set
//   pop_ready    : per-port ready (only the selected port's bit matters)
//   pop_data     : per-port payload, all driven from the head entry
//   drop         : 1-cycle pulse after an out-of-range beat was discarded
module br_demux_bin_flow_reg
    import br_demux_bin_pkg::*;
#(
    parameter  int NumSymbolsOut = 2,
    parameter  int SymbolWidth   = 1,
    localparam int SelectWidth   = $clog2(NumSymbolsOut)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    push_valid,
    output logic                                    push_ready,
    input  logic [SelectWidth-1:0]                  push_select,
    input  logic [SymbolWidth-1:0]                  push_data,
    output logic [NumSymbolsOut-1:0]                pop_valid,
    input  logic [NumSymbolsOut-1:0]                pop_ready,
    output logic [NumSymbolsOut-1:0][SymbolWidth-1:0] pop_data,
    output logic                                    drop
);

    br_demux_bin_state_e state, state_next;

    logic                   head_valid;
    logic [SymbolWidth-1:0] head_data;
    logic [SelectWidth-1:0] head_sel;
    logic                   head_load;
    logic                   head_clear;
    logic [SymbolWidth-1:0] head_in_data;
    logic [SelectWidth-1:0] head_in_sel;

    logic push_fire;
    logic pop_fire;
    logic in_range;
    logic enq;

    always_comb begin
        pop_valid = '0;
        pop_data  = '0;
        for (int unsigned i = 0; i < NumSymbolsOut; i++) begin
            pop_valid[i] = head_valid && (head_sel == SelectWidth'(i));
            pop_data[i]  = head_data;
        end
    end

    assign pop_fire  = |(pop_valid & pop_ready);
    assign in_range  = sel_in_range(32'(push_select), NumSymbolsOut);
    assign push_fire = push_valid && push_ready;
    // Out-of-range beats are consumed but never enqueued.
    assign enq       = push_fire && in_range;

    br_demux_bin_flow_reg_stage #(
        .SymbolWidth (SymbolWidth),
        .SelectWidth (SelectWidth)
    ) u_head (
        .clk       (clk),
        .rst       (rst),
        .load      (head_load),
        .clear     (head_clear),
        .in_data   (head_in_data),
        .in_select (head_in_sel),
        .valid     (head_valid),
        .data      (head_data),
        .select    (head_sel)
    );

`ifdef BR_DEMUX_BIN_FLOW_REG_SKID_EN
    logic                   push_ready_q;
    logic                   skid_valid;
    logic [SymbolWidth-1:0] skid_data;
    logic [SelectWidth-1:0] skid_sel;
    logic                   skid_load;
    logic                   skid_clear;

    br_demux_bin_flow_reg_stage #(
        .SymbolWidth (SymbolWidth),
        .SelectWidth (SelectWidth)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .in_data   (push_data),
        .in_select (push_select),
        .valid     (skid_valid),
        .data      (skid_data),
        .select    (skid_sel)
    );

    // Head always holds the oldest beat; skid only fills when the head
    // is occupied and not leaving, and refills the head on the next pop.
    always_comb begin
        state_next   = state;
        head_load    = 1'b0;
        head_clear   = 1'b0;
        head_in_data = push_data;
        head_in_sel  = push_select;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        case (state)
            EMPTY: begin
                if (enq) begin
                    head_load  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (enq && pop_fire) begin
                    head_load = 1'b1;
                end else if (enq) begin
                    skid_load  = 1'b1;
                    state_next = TWO;
                end else if (pop_fire) begin
                    head_clear = 1'b1;
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop_fire) begin
                    head_load    = 1'b1;
                    head_in_data = skid_data;
                    head_in_sel  = skid_sel;
                    skid_clear   = 1'b1;
                    state_next   = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign push_ready = push_ready_q;
`else
    always_comb begin
        head_in_data = push_data;
        head_in_sel  = push_select;
        head_load    = enq;
        head_clear   = pop_fire && !enq;
        state_next   = state;
        if (enq) begin
            state_next = ONE;
        end else if (pop_fire) begin
            state_next = EMPTY;
        end
    end

    assign push_ready = !head_valid || pop_fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            drop  <= 1'b0;
`ifdef BR_DEMUX_BIN_FLOW_REG_SKID_EN
            push_ready_q <= 1'b1;
`endif
        end else begin
            state <= state_next;
            drop  <= push_fire && !in_range;
`ifdef BR_DEMUX_BIN_FLOW_REG_SKID_EN
            push_ready_q <= (state_next != TWO);
`endif
        end
    end

    a_onehot_pop: assert property (@(posedge clk) disable iff (rst)
        $onehot0(pop_valid));

    a_push_hold: assert property (@(posedge clk) disable iff (rst)
        push_valid && !push_ready |=>
            push_valid && $stable(push_data) && $stable(push_select));

    a_drop_idle: assert property (@(posedge clk) disable iff (rst)
        !push_valid ##1 !push_valid |-> !drop);

    a_head_state: assert property (@(posedge clk) disable iff (rst)
        head_valid == (state != EMPTY));

`ifdef BR_DEMUX_BIN_FLOW_REG_SKID_EN
    a_skid_state: assert property (@(posedge clk) disable iff (rst)
        skid_valid == (state == TWO));
`endif

endmodule
